// File: rtl/id_ex_pipe_if.sv
// ID/EX stage bundle: decoded instruction fields entering EX and the registered
// copies presented to the execute stage.
interface id_ex_pipe_if;
   logic        RegDst_i;
   logic        ALUSrc_i;
   logic        MemtoReg_i;
   logic        RegWrite_i;
   logic        MemRead_i;
   logic        MemWrite_i;
   logic [1:0]  ALUOp_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic [31:0] imm_i;
   logic [4:0]  rs_addr_i;
   logic [4:0]  rt_addr_i;
   logic [4:0]  rd_addr_i;
   logic [5:0]  funct_i;
   logic        valid_i;

   logic        ex_RegDst_o;
   logic        ex_ALUSrc_o;
   logic        ex_MemtoReg_o;
   logic        ex_RegWrite_o;
   logic        ex_MemRead_o;
   logic        ex_MemWrite_o;
   logic [1:0]  ex_ALUOp_o;
   logic [31:0] ex_rs_data_o;
   logic [31:0] ex_rt_data_o;
   logic [31:0] ex_imm_o;
   logic [4:0]  ex_rs_addr_o;
   logic [4:0]  ex_rt_addr_o;
   logic [4:0]  ex_rd_addr_o;
   logic [5:0]  ex_funct_o;
   logic        ex_valid_o;

   modport master (
      output RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i,
             ALUOp_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i,
             rd_addr_i, funct_i, valid_i,
      input  ex_RegDst_o, ex_ALUSrc_o, ex_MemtoReg_o, ex_RegWrite_o,
             ex_MemRead_o, ex_MemWrite_o, ex_ALUOp_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_rs_addr_o, ex_rt_addr_o,
             ex_rd_addr_o, ex_funct_o, ex_valid_o
   );

   modport slave (
      input  RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i,
             ALUOp_i, rs_data_i, rt_data_i, imm_i, rs_addr_i, rt_addr_i,
             rd_addr_i, funct_i, valid_i,
      output ex_RegDst_o, ex_ALUSrc_o, ex_MemtoReg_o, ex_RegWrite_o,
             ex_MemRead_o, ex_MemWrite_o, ex_ALUOp_o, ex_rs_data_o,
             ex_rt_data_o, ex_imm_o, ex_rs_addr_o, ex_rt_addr_o,
             ex_rd_addr_o, ex_funct_o, ex_valid_o
   );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and a saturating bubble counter.
module id_ex_pipe (
   input  logic               clk_i,
   input  logic               rst_i,
   id_ex_pipe_if.slave        pipe,
   input  logic               flush_i,
   input  logic               hold_i,
   output logic               stall_o,
   output logic [15:0]        bubble_cnt_o
);

   typedef struct packed {
      logic        regdst;
      logic        alusrc;
      logic        memtoreg;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic [1:0]  aluop;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
      logic [5:0]  funct;
      logic        valid;
   } stage_t;

   stage_t      id_stage;
   stage_t      ex_q, ex_d;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic        load_use;

   // Side-effecting controls are squashed for non-instructions so X never leaks into EX.
   always_comb begin
      id_stage          = '0;
      id_stage.regdst   = pipe.RegDst_i;
      id_stage.alusrc   = pipe.ALUSrc_i;
      id_stage.memtoreg = pipe.MemtoReg_i;
      id_stage.regwrite = pipe.RegWrite_i & pipe.valid_i;
      id_stage.memread  = pipe.MemRead_i  & pipe.valid_i;
      id_stage.memwrite = pipe.MemWrite_i & pipe.valid_i;
      id_stage.aluop    = pipe.ALUOp_i;
      id_stage.rs_data  = pipe.rs_data_i;
      id_stage.rt_data  = pipe.rt_data_i;
      id_stage.imm      = pipe.imm_i;
      id_stage.rs_addr  = pipe.rs_addr_i;
      id_stage.rt_addr  = pipe.rt_addr_i;
      id_stage.rd_addr  = pipe.rd_addr_i;
      id_stage.funct    = pipe.funct_i;
      id_stage.valid    = pipe.valid_i;
   end

   assign load_use = pipe.valid_i & ex_q.valid & ex_q.memread &
                     (ex_q.rt_addr != 5'd0) &
                     ((ex_q.rt_addr == pipe.rs_addr_i) | (ex_q.rt_addr == pipe.rt_addr_i));

   assign stall_o = load_use | hold_i;

   always_comb begin
      // NOTE: defaults first so every path assigns every bit and no latch is inferred.
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
      if (!hold_i) begin
         if (flush_i) begin
            ex_d = '0;
         end else if (load_use) begin
            ex_d = '0;
            if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
         end else begin
            ex_d = id_stage;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o       = bubble_cnt_q;
   assign pipe.ex_RegDst_o   = ex_q.regdst;
   assign pipe.ex_ALUSrc_o   = ex_q.alusrc;
   assign pipe.ex_MemtoReg_o = ex_q.memtoreg;
   assign pipe.ex_RegWrite_o = ex_q.regwrite;
   assign pipe.ex_MemRead_o  = ex_q.memread;
   assign pipe.ex_MemWrite_o = ex_q.memwrite;
   assign pipe.ex_ALUOp_o    = ex_q.aluop;
   assign pipe.ex_rs_data_o  = ex_q.rs_data;
   assign pipe.ex_rt_data_o  = ex_q.rt_data;
   assign pipe.ex_imm_o      = ex_q.imm;
   assign pipe.ex_rs_addr_o  = ex_q.rs_addr;
   assign pipe.ex_rt_addr_o  = ex_q.rt_addr;
   assign pipe.ex_rd_addr_o  = ex_q.rd_addr;
   assign pipe.ex_funct_o    = ex_q.funct;
   assign pipe.ex_valid_o    = ex_q.valid;

endmodule
